// File: rtl/datamem_responder_if.sv
// Request/response bus between a load/store unit and datamem_responder.
// Master drives requests and response acceptance; slave answers.
interface datamem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [3:0]  req_size;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_error;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_size,
      output resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_size,
      input  resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/datamem_responder.sv
// Multi-cycle byte-addressed data memory with fixed response latency.
// Define DATAMEM_STATS_EN to add load/store/error response counters.
module datamem_responder #(
   parameter int DEPTH_BYTES = 1024,
   parameter int LATENCY     = 3
) (
   input  logic clk,
   input  logic reset,
`ifdef DATAMEM_STATS_EN
   output logic [31:0] load_count,
   output logic [31:0] store_count,
   output logic [31:0] error_count,
`endif
   datamem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH_BYTES);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          write_q;
   logic [63:0]   addr_q;
   logic [63:0]   wdata_q;
   logic [3:0]    size_q;

   logic [7:0]    mem [DEPTH_BYTES];

   logic [64:0]   end_addr;
   logic          size_ok;
   logic          align_ok;
   logic          range_ok;
   logic          err;
   logic          finish;
   logic [AW-1:0] idx;
   logic [63:0]   rd_word;

   assign bus.req_ready = (state == IDLE);

   // 65-bit sum so a wrapped address cannot look in range
   assign end_addr = {1'b0, addr_q} + 65'(size_q);
   assign size_ok  = (size_q == 4'd1) || (size_q == 4'd2) ||
                     (size_q == 4'd4) || (size_q == 4'd8);
   assign align_ok = (addr_q[2:0] & (size_q[2:0] - 3'd1)) == 3'd0;
   assign range_ok = end_addr <= 65'(DEPTH_BYTES);
   assign err      = !(size_ok && align_ok && range_ok);
   assign finish   = (state == WAIT) && (cnt == '0);
   assign idx      = addr_q[AW-1:0];

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < 8; i++) begin
         if (4'(i) < size_q)
            rd_word[8*i +: 8] = mem[idx + AW'(i)];
      end
   end

   always_ff @(posedge clk) begin
      if (finish && write_q && !err) begin
         for (int i = 0; i < 8; i++) begin
            if (4'(i) < size_q)
               mem[idx + AW'(i)] <= wdata_q[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         write_q        <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         size_q         <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_error <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  write_q <= bus.req_write;
                  addr_q  <= bus.req_addr;
                  wdata_q <= bus.req_wdata;
                  size_q  <= bus.req_size;
                  cnt     <= CW'(LATENCY - 1);
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state          <= RESP;
                  bus.resp_valid <= 1'b1;
                  bus.resp_error <= err;
                  bus.resp_rdata <= (!write_q && !err) ? rd_word : '0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RESP: begin
               if (bus.resp_ready) begin
                  state          <= IDLE;
                  bus.resp_valid <= 1'b0;
                  bus.resp_rdata <= '0;
                  bus.resp_error <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DATAMEM_STATS_EN
   logic done;
   assign done = (state == RESP) && bus.resp_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_count  <= '0;
         store_count <= '0;
         error_count <= '0;
      end else if (done) begin
         if (err) begin
            if (error_count != '1) error_count <= error_count + 32'd1;
         end else if (write_q) begin
            if (store_count != '1) store_count <= store_count + 32'd1;
         end else begin
            if (load_count != '1) load_count <= load_count + 32'd1;
         end
      end
   end
`endif
endmodule

// File: doc/datamem_responder.md
Name: datamem_responder

Overview:
Data-memory responder that sits behind the CPU's load/store path and replaces the ideal single-cycle data memory. It accepts one byte-addressed request at a time over a valid/ready handshake and returns a response after a fixed programmable latency. Responses carry read data or an error flag. The block exists so that stall-capable pipelines can be exercised against a multi-cycle memory.

Parameters:
DEPTH_BYTES, 1024, storage size in bytes; must be a power of two and at least 8.
LATENCY, 3, cycles from request accept to response valid; must be at least 1.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  64  byte address
req_wdata  input  64  store data; bytes beyond the transfer size are ignored
req_size  input  4  transfer bytes; legal values are 1, 2, 4 and 8
resp_valid  output  1  response present
resp_ready  input  1  requester accepts the response
resp_rdata  output  64  load data, zero-extended; 0 for stores and on error
resp_error  output  1  request was illegal

Behaviour:
- Interface: one clock domain. Reset is asynchronous and active-high. The clock port is named clk and the reset port is named reset.
- Reset values:
  - State returns to IDLE.
  - req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_error=0.
  - Storage array is not reset; its contents are undefined until written.
- FSM states are IDLE, WAIT and RESP.
- req_ready equals (state==IDLE) and is never asserted in WAIT or RESP.
- IDLE:
  - Accept occurs on clock edge N when req_valid && req_ready.
  - On accept, latch write, addr, wdata and size.
  - Load latency counter with LATENCY-1 and go to WAIT.
- WAIT:
  - If the counter is 0, go to RESP; otherwise decrement the counter.
  - resp_valid therefore rises after edge N+LATENCY.
- WAIT to RESP edge:
  - Perform the memory access.
  - A legal store commits its bytes at this edge.
  - A legal load captures its bytes into resp_rdata at this edge.
- RESP:
  - resp_valid=1; resp_rdata and resp_error are held stable until resp_ready.
  - On the resp_valid && resp_ready edge: go to IDLE and clear resp_valid, resp_rdata and resp_error to 0.
- No overlap: the earliest next accept is the cycle after the response handshake. req_valid asserted outside IDLE is ignored.
- Byte order is little-endian: byte at addr maps to bits [7:0], byte at addr+1 maps to bits [15:8], and so on.
  - Stores modify only the addressed bytes.
  - Loads of 1, 2 or 4 bytes are zero-extended.
- Error conditions (checked on latched values):
  - size not in {1,2,4,8};
  - addr mod size != 0;
  - addr+size > DEPTH_BYTES, computed without 64-bit wrap.
- On error:
  - No storage change; resp_rdata=0, resp_error=1.
  - Latency is the same as for a legal request.
- Reset mid-operation: a pending store in WAIT is dropped and never commits. A response pending in RESP is discarded.
- Address bits above log2(DEPTH_BYTES) take part only in the range check; they never alias into the array.

Optional Feature:
DATAMEM_STATS_EN
- When defined, adds three output ports: load_count (32), store_count (32) and error_count (32).
  - Each resets to 0.
  - Each increments by 1 on the response handshake edge for its category. Errored requests count only in error_count.
  - Each saturates at 32'hFFFFFFFF.
- When undefined, the ports and their counter logic are absent.
- Core behaviour is identical either way.

Test Plan:
1. LATENCY=3; store size 8 of 0x0123456789ABCDEF at 0x10, accepted at edge N → resp_valid rises after N+3 with resp_error=0 and resp_rdata=0. Load size 8 at 0x10 → rdata=0x0123456789ABCDEF.
2. Store size 1 of 0xAA at 0x13, then load size 8 at 0x10 → 0x01234567AAABCDEF. Load size 2 at 0x12 → 0x000000000000AAAB.
3. Load size 4 at 0x12 → resp_error=1, rdata=0. Store size 2 at 0x11 → resp_error=1. Load size 3 at 0x10 → resp_error=1. Subsequent load size 8 at 0x10 → still 0x01234567AAABCDEF.
4. Range checks with DEPTH_BYTES=1024:
   - load size 8 at 0x3F8 → resp_error=0;
   - load size 8 at 0x400 → resp_error=1;
   - load at 0xFFFFFFFFFFFFFFF8 → resp_error=1.
5. Backpressure:
   - Hold resp_ready=0 for 5 cycles while pulsing req_valid → resp_valid, rdata and error stay stable and req_ready=0.
   - Release resp_ready → req_ready=1 in the next cycle, and only then is a new request accepted.
6. Reset mid-WAIT:
   - Issue a store of 0xFFFFFFFFFFFFFFFF to 0x10, then assert reset one cycle after accept → all outputs return to reset values immediately.
   - A later load size 8 at 0x10 returns 0x01234567AAABCDEF.
   - With DATAMEM_STATS_EN defined, all counters read 0 after reset.
